// File: rtl/par_to_serial_tx_pkg.sv
// Shared PHY constants and types for the transmit lane.
// Holds the idle/comma byte, preamble floor and tx state encoding.
package par_to_serial_tx_pkg;

  localparam logic [7:0] IDLE_CHAR = 8'hBC;

  // Shared with the receiver's comma-count threshold.
  localparam int PREAMBLE_MIN = 5;

  typedef enum logic {
    ST_PREAMBLE = 1'b0,
    ST_ACTIVE   = 1'b1
  } tx_state_e;

endpackage

// File: rtl/par_to_serial_tx_fifo.sv
// phy_sync_fifo: synchronous FIFO on clk_32f, sync active-high reset.
// Ports: push/wdata in, pop/rdata (head, comb) out, full/empty/count.
module phy_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_32f) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/par_to_serial_tx.sv
// Byte-to-serial transmitter: FIFO in, MSB-first bits out, comma preamble.
// Ports: clk_32f, reset, data_in/valid_in/ready_out, data_out, byte_strobe, active.
module par_to_serial_tx
  import par_to_serial_tx_pkg::*;
#(
  parameter int PREAMBLE_CNT = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(PREAMBLE_CNT + 1);

  tx_state_e     state_q;
  tx_state_e     state_d;
  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_cnt_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    next_byte;
  logic          load;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign ready_out = (fifo_count < CW'(FIFO_DEPTH)) && !reset;
  assign push      = valid_in && !fifo_full && !reset;
  assign load      = (bit_cnt == 3'd7);
  assign active    = (state_q == ST_ACTIVE);

  phy_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_32f (clk_32f),
    .reset   (reset),
    .push    (push),
    .wdata   (data_in),
    .pop     (pop),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // On the edge the preamble finishes, the ACTIVE rule already applies,
  // so the first post-preamble byte may be queued data.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt;
    pop       = 1'b0;
    next_byte = IDLE_CHAR;
    if (load) begin
      if (state_q == ST_PREAMBLE &&
          pre_cnt != PW'(PREAMBLE_CNT)) begin
        pre_cnt_d = pre_cnt + PW'(1);
      end else begin
        state_d = ST_ACTIVE;
        if (!fifo_empty) begin
          pop       = 1'b1;
          next_byte = fifo_head;
        end
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q <= ST_PREAMBLE;
      pre_cnt <= '0;
    end else begin
      state_q <= state_d;
      pre_cnt <= pre_cnt_d;
    end
  end

  // bit_cnt resets to 7 so the first edge out of reset loads a byte;
  // the 3-bit increment wraps 7->0 on load edges.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bit_cnt     <= 3'd7;
      shreg       <= '0;
      data_out    <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      bit_cnt     <= bit_cnt + 3'd1;
      byte_strobe <= load;
      if (load) begin
        shreg    <= next_byte;
        data_out <= next_byte[7];
      end else begin
        shreg    <= {shreg[6:0], 1'b0};
        data_out <= shreg[6];
      end
    end
  end

endmodule

// File: doc/par_to_serial_tx.md
# par_to_serial_tx

Byte-wide to serial transmitter for the PHY transmit lane. It is the upstream stage of the lane's serial-to-parallel receiver. It accepts bytes through a valid/ready handshake into a small FIFO and serializes them MSB-first, one bit per clk_32f cycle. It emits an IDLE_CHAR (0xBC) comma preamble after reset and IDLE_CHAR whenever no data is pending, so the receiver can detect framing and go active.

## Interface
- IDLE_CHAR, 8'hBC, comma/idle byte sent during the preamble and when the FIFO is empty
- PREAMBLE_CNT, 8, number of IDLE_CHAR bytes sent after reset before data is allowed; ≥5 so the receiver reaches active
- FIFO_DEPTH, 4, input FIFO entries; power of two, ≥2
- clk_32f  in  1  bit clock; one serial bit per rising edge; the only clock
- reset  in  1  synchronous, active-high reset
- data_in  in  8  parallel byte to transmit
- valid_in  in  1  data_in is valid this cycle
- ready_out  out  1  FIFO can accept a byte; = (count < FIFO_DEPTH) && !reset, combinational
- data_out  out  1  serial bit stream, MSB first, registered
- byte_strobe  out  1  registered; high in the cycle data_out carries bit 7 of a new byte
- active  out  1  registered; high once the preamble has completed

## Operation
- Reset, sampled on a clk_32f edge with reset=1:
  - data_out=0, byte_strobe=0, active=0.
  - bit_cnt=7, preamble counter=0, FIFO emptied, shift register=0.
- bit_cnt is 3 bits and runs 0..7, wrapping 7→0.
- Load edge: the edge where pre-edge bit_cnt==7.
  - Load the next byte into the shift register.
  - Drive its bit 7 on data_out.
  - byte_strobe<=1; bit_cnt<=0.
- Other edges: shift left, drive the next bit, byte_strobe<=0, bit_cnt+1.
- Byte source on a load edge, decided from pre-edge state:
  - State PREAMBLE (active=0):
    - If preamble count < PREAMBLE_CNT: load IDLE_CHAR and increment the count.
    - If preamble count == PREAMBLE_CNT: set active<=1 and use the ACTIVE rule on this same edge.
  - State ACTIVE (active=1): if the FIFO is non-empty, pop the head and load it; otherwise load IDLE_CHAR.
  - ACTIVE is left only by reset.
- FIFO push: on any edge with valid_in && ready_out, including load edges. A simultaneous pop and push is legal; the count is unchanged.
- valid_in while ready_out=0 is ignored (byte not stored, no state change). The source must hold data until accepted.
- A push on a load edge is not visible to that load; the byte goes out at the next byte boundary.
- A data byte equal to IDLE_CHAR is sent unmodified. The receiver treats it as idle. Sources must not send IDLE_CHAR as payload.
- Reset asserted mid-byte aborts the byte. FIFO contents are discarded, and the preamble restarts after release.

## Timing
- First edge with reset=0 is a load edge: data_out=bit 7 of IDLE_CHAR (1) and byte_strobe=1 after that edge.
- Byte period: exactly 8 cycles. byte_strobe pulses every 8th cycle, never 2 cycles in a row.
- active rises on the load edge of byte index PREAMBLE_CNT (0-based after reset), i.e. cycle 8×PREAMBLE_CNT after release. That byte may already be FIFO data.
- Push-to-first-bit latency: 1 to 8 cycles when the FIFO is empty and active=1; longer behind queued bytes.
- ready_out drops in the same cycle the count reaches FIFO_DEPTH, and rises combinationally after a pop.

## Structure
- Shared PHY package/include holds:
  - IDLE_CHAR (8'hBC).
  - Minimum preamble constant 5, shared with the receiver's bc count threshold.
- One sub-module: phy_sync_fifo, a parameterized synchronous FIFO (depth, width 8, push/pop, full/empty/count, same clk_32f and reset).
- Top level holds the bit counter, preamble counter, state, and shift register.

## Test plan
- Reset release, no valid_in: data_out repeats 10111100 every 8 cycles; byte_strobe on the first bit; active=1 at cycle 64 (PREAMBLE_CNT=8).
- Push 0xA5 at cycle 10 (PREAMBLE): bytes 1..7 stay 0xBC; byte 8 (cycle 64) = 10100101; then 0xBC resumes.
- Back-to-back pushes 0x01,0x02,0x03,0x04,0x05 after active: ready_out=0 after 4 accepted (or 5 if a pop occurs in between); bytes come out in order with no gap or idle between them.
- Push on a load edge with the FIFO empty: that byte is 0xBC; pushed byte follows on the next boundary.
- Reset pulse mid-byte while the FIFO holds 3 bytes: outputs return to 0; after release, 8 preamble bytes; the held bytes are never transmitted.
- Loopback into the serial-to-parallel receiver with the 8-cycle strobe aligned to its clk_4f: receiver goes active and reproduces the pushed byte sequence with valid_out=1.
